vblank_access_scheduler: RTL and testbench
==========================================

# vblank_access_scheduler

Arbitrates a shared frame-state resource (sprite/position RAM write port) between up to N_REQ game-logic requesters, granting access only during the vertical blanking window of the 800x600@60 timing generator. Sits beside the timing generator on the pclk domain and consumes its vertical count and vertical blank. Emits a per-frame tick and frame counter for game logic, and guarantees that no writer owns the resource during active video.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- LINE_LAST, 627, last line of the frame (vcount wraps after it)
- GUARD_LINES, 2, trailing vblank lines in which no new grant is issued
- MAX_HOLD, 2048, maximum cycles a grant may be held before forced revoke

Ports:
- pclk  in  1  pixel clock (40 MHz); all logic on rising edge
- rst  in  1  synchronous, active-high reset
- vcount_in  in  11  vertical count from timing generator
- vblnk_in  in  1  vertical blank from timing generator
- req  in  N_REQ  per-requester access request, level
- done  in  N_REQ  per-requester release, sampled only from current owner
- gnt  out  N_REQ  one-hot grant, registered
- frame_tick  out  1  one-cycle pulse at start of each vblank
- window_open  out  1  high while scheduler considers vblank window active
- timeout_err  out  1  one-cycle pulse on forced revoke
- frame_cnt  out  16  frames since reset, wraps 65535→0
- busy  out  1  high while any gnt bit is high

## Operation
- Reset: gnt=0, frame_tick=0, window_open=0, timeout_err=0, frame_cnt=0, busy=0, state IDLE, RR pointer=N_REQ-1 (requester 0 wins first), vblnk_d=1, hold counter=0.
- vblnk_d reset to 1: reset asserted mid-vblank produces no tick until the next genuine rising edge.
- States: IDLE, ARB, GRANT, CLOSED.
- IDLE: on vblnk_in=1 & vblnk_d=0 → frame_tick pulse, frame_cnt+1, window_open=1, go ARB.
- ARB: if vblnk_in=0 → IDLE, window_open=0. Else if vcount_in > LINE_LAST-GUARD_LINES → CLOSED. Else if req≠0 → grant first set bit searching from pointer+1 upward modulo N_REQ, go GRANT, clear hold counter. Else stay.
- GRANT: hold counter increments each cycle gnt is high.
  - done[owner]=1 → release, pointer=owner, go ARB.
  - vblnk_in=0 → revoke, no timeout_err, window_open=0, go IDLE (highest priority).
  - hold counter reaches MAX_HOLD without done → revoke, timeout_err pulse, pointer=owner, go ARB.
  - req[owner] dropping is ignored; done from non-owners is ignored.
- CLOSED: window_open stays 1, no grants; vblnk_in=0 → IDLE, window_open=0.
- Simultaneous done and vblnk fall: treated as vblnk fall (no timeout_err). Simultaneous done and timeout: done wins, no timeout_err.
- Exactly one gnt bit high at most, ever.

## Timing
- All outputs registered.
- vblnk rise sampled at cycle t (vblnk_in=1, vblnk_d=0) → frame_tick and window_open high at t+1; frame_tick low at t+2.
- Grant latency: req seen in ARB at cycle t → gnt high at t+1.
- Release: done[owner] at cycle t → gnt low at t+1; earliest next grant at t+2 (one dead cycle minimum).
- Timeout: gnt high for exactly MAX_HOLD cycles; gnt low and timeout_err high in the same cycle, following the MAX_HOLD-th cycle.
- vblnk fall at cycle t → gnt, busy, window_open low at t+1.
- Guard: with defaults, grants only while vcount_in ≤ 625; a grant issued at line 625 may be held into 626/627.

## Test plan
- Reset, one frame with req=0: vblnk rises at line 600 → single frame_tick, frame_cnt 0→1, window_open high until vblnk falls, gnt stays 0.
- req=4'b1111 steady, each owner asserts done 3 cycles after grant → grant order 0,1,2,3,0,… with each gnt 3 cycles high and exactly 1 dead cycle between grants.
- MAX_HOLD=16, req=4'b0110, requester 1 never asserts done → gnt[1] high 16 cycles, timeout_err one pulse on release, gnt[2] asserted 1 cycle later.
- req[0] first asserted with vcount_in=626 → no grant that frame; window_open stays high; gnt[0] issued 1 cycle into the next vblank.
- vblnk falls while gnt[3] held → gnt=0 and window_open=0 next cycle, timeout_err stays 0; frame_cnt 65535 + next tick → 0.
- rst pulsed mid-grant during vblank → all outputs 0 next cycle; no frame_tick until the following vblank rising edge; then requester 0 granted first.

Source files
------------

// File: rtl/vblank_access_scheduler.sv
// ---------------------------------------------------------------------------
// vblank_access_scheduler
//
// Arbitrates the sprite/position RAM write port between N_REQ game-logic
// requesters. Access is granted only inside the vertical blanking window
// reported by the 800x600@60 timing generator, so no writer can own the
// resource while pixels are being fetched for active video. The block also
// publishes a per-frame tick and a free-running frame counter for game logic.
//
// Parameters
//   N_REQ        number of requesters (2..8)
//   LINE_LAST    last line of the frame; vcount wraps after it
//   GUARD_LINES  trailing vblank lines in which no new grant is issued
//   MAX_HOLD     cycles a grant may be held before it is forcibly revoked
//
// Ports
//   pclk         pixel clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   vcount_in    vertical line count from the timing generator
//   vblnk_in     vertical blank from the timing generator
//   req          per-requester access request (level)
//   done         per-requester release, only the current owner's bit matters
//   gnt          one-hot registered grant
//   frame_tick   one-cycle pulse at the start of each vblank
//   window_open  high while the scheduler treats the vblank window as active
//   timeout_err  one-cycle pulse when a grant is forcibly revoked
//   frame_cnt    frames since reset, wraps 65535 -> 0
//   busy         high while any gnt bit is high
// ---------------------------------------------------------------------------
module vblank_access_scheduler #(
    parameter int N_REQ       = 4,
    parameter int LINE_LAST   = 627,
    parameter int GUARD_LINES = 2,
    parameter int MAX_HOLD    = 2048
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [10:0]      vcount_in,
    input  logic             vblnk_in,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic             frame_tick,
    output logic             window_open,
    output logic             timeout_err,
    output logic [15:0]      frame_cnt,
    output logic             busy
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // One extra count of headroom: the counter steps once more on the
    // revoking edge itself.
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    // Highest line on which a new grant may still be issued.
    localparam logic [10:0]       LAST_GRANT_LINE = 11'(LINE_LAST - GUARD_LINES);
    // Counter value during the MAX_HOLD-th cycle of a grant.
    localparam logic [HOLD_W-1:0] HOLD_LAST       = HOLD_W'(MAX_HOLD - 1);
    // Pointer reset value: the search starts at pointer+1, so requester 0
    // wins the first arbitration after reset.
    localparam logic [IDX_W-1:0]  PTR_INIT        = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,   // outside the window, waiting for vblank to rise
        ARB    = 2'd1,   // window open, looking for a requester
        GRANT  = 2'd2,   // one requester owns the write port
        CLOSED = 2'd3    // guard lines reached, window open but no grants
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t            state;
    logic [IDX_W-1:0]  ptr;        // last owner served; search starts after it
    logic [IDX_W-1:0]  owner;      // index of the current grant holder
    logic [HOLD_W-1:0] hold_cnt;   // cycles the current grant has been held
    logic              vblnk_d;    // vblnk_in one cycle ago, for edge detect

    // -----------------------------------------------------------------------
    // Combinational decode
    // -----------------------------------------------------------------------
    logic              vblnk_rise;
    logic              guard_hit;
    logic              owner_done;
    logic              hold_expired;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;

    // Requester index offset places after base, wrapped modulo N_REQ.
    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int offs);
        return IDX_W'((base + offs) % N_REQ);
    endfunction

    assign vblnk_rise   = vblnk_in & ~vblnk_d;
    assign guard_hit    = (vcount_in > LAST_GRANT_LINE);
    assign owner_done   = done[owner];
    assign hold_expired = (hold_cnt == HOLD_LAST);

    // Round-robin pick: walk offsets from N_REQ down to 1 so the smallest
    // offset past the pointer is the last writer and therefore wins.
    // NOTE: both outputs get a default before the loop; without it a
    // pass where no request is set would leave them unassigned and
    // synthesis would infer latches.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req[wrap_idx(int'(ptr), i)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_idx(int'(ptr), i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scheduler FSM with registered outputs
    // -----------------------------------------------------------------------
    // NOTE: every register here is assigned with <= so all of them update
    // from the same pre-edge values; a blocking = would let later
    // statements see half-updated state and break the FSM ordering.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= PTR_INIT;
            owner       <= '0;
            hold_cnt    <= '0;
            // NOTE: the edge detector resets to 1, not 0, so a reset
            // released in the middle of vblank is not mistaken for a new
            // frame; the first tick waits for a genuine rising edge.
            vblnk_d     <= 1'b1;
            gnt         <= '0;
            frame_tick  <= 1'b0;
            window_open <= 1'b0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
            busy        <= 1'b0;
        end else begin
            vblnk_d     <= vblnk_in;
            // Pulses default low and are raised only on their event cycle.
            frame_tick  <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (vblnk_rise) begin
                        frame_tick  <= 1'b1;
                        frame_cnt   <= frame_cnt + 16'd1;
                        window_open <= 1'b1;
                        state       <= ARB;
                    end
                end

                ARB: begin
                    if (!vblnk_in) begin
                        window_open <= 1'b0;
                        state       <= IDLE;
                    end else if (guard_hit) begin
                        // Too close to active video to start a new write.
                        state <= CLOSED;
                    end else if (pick_valid) begin
                        gnt      <= N_REQ'(1) << pick_idx;
                        busy     <= 1'b1;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end

                GRANT: begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (!vblnk_in) begin
                        // Active video is about to start: revoke at once.
                        // This outranks both done and the hold timeout.
                        gnt         <= '0;
                        busy        <= 1'b0;
                        window_open <= 1'b0;
                        state       <= IDLE;
                    end else if (owner_done) begin
                        // A release on the timeout cycle is a clean release.
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= owner;
                        state <= ARB;
                    end else if (hold_expired) begin
                        gnt         <= '0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        ptr         <= owner;
                        state       <= ARB;
                    end
                end

                CLOSED: begin
                    if (!vblnk_in) begin
                        window_open <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    gnt         <= '0;
                    busy        <= 1'b0;
                    window_open <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vblank_access_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vblank_access_scheduler
//
// Directed bench for vblank_access_scheduler. Inputs are driven 1 ns after
// each rising edge and outputs are compared at the same point, so every
// observation reflects the decision taken on the edge just passed.
// MAX_HOLD is shortened to 16 so the forced-revoke path is reachable quickly.
// ---------------------------------------------------------------------------
module tb_vblank_access_scheduler;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic [10:0] vcount_in = '0;
    logic        vblnk_in  = 1'b0;
    logic [3:0]  req  = '0;
    logic [3:0]  done = '0;
    logic [3:0]  gnt;
    logic        frame_tick;
    logic        window_open;
    logic        timeout_err;
    logic [15:0] frame_cnt;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    vblank_access_scheduler #(
        .N_REQ      (4),
        .LINE_LAST  (627),
        .GUARD_LINES(2),
        .MAX_HOLD   (16)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .vcount_in  (vcount_in),
        .vblnk_in   (vblnk_in),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .frame_tick (frame_tick),
        .window_open(window_open),
        .timeout_err(timeout_err),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    always #5 pclk = ~pclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // {gnt, frame_tick, window_open, timeout_err, busy}
    task automatic test_reset();
        rst = 1'b1; vcount_in = 11'd0; vblnk_in = 1'b0; req = '0; done = '0;
        tick(); tick();
        n_vec++;
        if ({gnt, frame_tick, window_open, timeout_err, busy} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected %b",
                     {gnt, frame_tick, window_open, timeout_err, busy}, 8'h00);
        end
        n_vec++;
        if (frame_cnt !== 16'd0) begin
            n_err++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if ({gnt, frame_tick, window_open, busy} !== 7'h00) begin
            n_err++;
            $display("FAIL post_reset_idle: got %b expected %b",
                     {gnt, frame_tick, window_open, busy}, 7'h00);
        end
    endtask

    task automatic test_idle_frame();
        int ticks = 0;
        vcount_in = 11'd599;
        tick();
        vcount_in = 11'd600; vblnk_in = 1'b1;
        tick();
        n_vec++;
        if ({frame_tick, window_open} !== 2'b11 || frame_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL idle_tick: got tick=%b win=%b cnt=%0d expected tick=1 win=1 cnt=1",
                     frame_tick, window_open, frame_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            vcount_in = 11'(601 + i);
            tick();
            ticks += int'(frame_tick);
            n_vec++;
            if (gnt !== 4'b0000 || window_open !== 1'b1) begin
                n_err++;
                $display("FAIL idle_window: got gnt=%b win=%b expected gnt=0000 win=1",
                         gnt, window_open);
            end
        end
        n_vec++;
        if (ticks != 0) begin
            n_err++; $display("FAIL idle_single_tick: got %0d extra ticks expected 0", ticks);
        end
        vblnk_in = 1'b0; vcount_in = 11'd0;
        tick();
        n_vec++;
        if (window_open !== 1'b0 || frame_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL idle_close: got win=%b cnt=%0d expected win=0 cnt=1",
                     window_open, frame_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        req = 4'b1111; vblnk_in = 1'b1; vcount_in = 11'd600;
        tick();
        n_vec++;
        if (frame_cnt !== 16'd2) begin
            n_err++; $display("FAIL rr_frame_cnt: got %0d expected 2", frame_cnt);
        end
        tick();
        for (int g = 0; g < 5; g++) begin
            exp = 4'b0001 << (g % 4);
            for (int c = 0; c < 3; c++) begin
                n_vec++;
                if (gnt !== exp || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL rr_gnt g%0d c%0d: got gnt=%b busy=%b expected gnt=%b busy=1",
                             g, c, gnt, busy, exp);
                end
                if (c == 2) done = exp;
                tick();
            end
            done = '0;
            n_vec++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL rr_dead g%0d: got gnt=%b busy=%b expected gnt=0000 busy=0",
                         g, gnt, busy);
            end
            if (g == 4) req = '0;
            tick();
        end
        n_vec++;
        if (gnt !== 4'b0000) begin
            n_err++; $display("FAIL rr_idle_req: got %b expected 0000", gnt);
        end
        vblnk_in = 1'b0; vcount_in = 11'd0;
        tick();
        n_vec++;
        if (window_open !== 1'b0) begin
            n_err++; $display("FAIL rr_close: got %b expected 0", window_open);
        end
    endtask

    task automatic test_timeout();
        req = 4'b0110; vblnk_in = 1'b1; vcount_in = 11'd600;
        tick();
        tick();
        for (int c = 0; c < 16; c++) begin
            n_vec++;
            if (gnt !== 4'b0010 || timeout_err !== 1'b0) begin
                n_err++;
                $display("FAIL to_hold c%0d: got gnt=%b err=%b expected gnt=0010 err=0",
                         c, gnt, timeout_err);
            end
            tick();
        end
        n_vec++;
        if (gnt !== 4'b0000 || timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL to_revoke: got gnt=%b err=%b expected gnt=0000 err=1",
                     gnt, timeout_err);
        end
        tick();
        n_vec++;
        if (gnt !== 4'b0100 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL to_next: got gnt=%b err=%b expected gnt=0100 err=0",
                     gnt, timeout_err);
        end
        done = 4'b0100; req = '0;
        tick();
        done = '0;
        n_vec++;
        if (gnt !== 4'b0000) begin
            n_err++; $display("FAIL to_release: got %b expected 0000", gnt);
        end
        vblnk_in = 1'b0; vcount_in = 11'd0;
        tick();
    endtask

    task automatic test_guard();
        vblnk_in = 1'b1; vcount_in = 11'd600; req = '0;
        tick();
        vcount_in = 11'd626; req = 4'b0001;
        tick();
        n_vec++;
        if (gnt !== 4'b0000 || window_open !== 1'b1) begin
            n_err++;
            $display("FAIL guard_626: got gnt=%b win=%b expected gnt=0000 win=1", gnt, window_open);
        end
        vcount_in = 11'd627;
        tick(); tick();
        n_vec++;
        if (gnt !== 4'b0000 || window_open !== 1'b1) begin
            n_err++;
            $display("FAIL guard_627: got gnt=%b win=%b expected gnt=0000 win=1", gnt, window_open);
        end
        vblnk_in = 1'b0; vcount_in = 11'd0;
        tick();
        n_vec++;
        if (gnt !== 4'b0000 || window_open !== 1'b0) begin
            n_err++;
            $display("FAIL guard_fall: got gnt=%b win=%b expected gnt=0000 win=0", gnt, window_open);
        end
        tick();
        vblnk_in = 1'b1; vcount_in = 11'd600;
        tick();
        n_vec++;
        if (frame_tick !== 1'b1 || gnt !== 4'b0000 || frame_cnt !== 16'd5) begin
            n_err++;
            $display("FAIL guard_next_tick: got tick=%b gnt=%b cnt=%0d expected tick=1 gnt=0000 cnt=5",
                     frame_tick, gnt, frame_cnt);
        end
        tick();
        n_vec++;
        if (gnt !== 4'b0001) begin
            n_err++; $display("FAIL guard_next_gnt: got %b expected 0001", gnt);
        end
        // A grant issued on line 625 is legal and may run into the guard lines.
        done = 4'b0001; req = 4'b0010; vcount_in = 11'd625;
        tick();
        done = '0;
        tick();
        n_vec++;
        if (gnt !== 4'b0010) begin
            n_err++; $display("FAIL guard_625_gnt: got %b expected 0010", gnt);
        end
        vcount_in = 11'd626;
        tick();
        vcount_in = 11'd627;
        tick();
        n_vec++;
        if (gnt !== 4'b0010 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL guard_hold_627: got gnt=%b busy=%b expected gnt=0010 busy=1", gnt, busy);
        end
        done = 4'b0010; req = '0;
        tick();
        done = '0; vblnk_in = 1'b0; vcount_in = 11'd0;
        tick();
    endtask

    task automatic test_vblnk_fall();
        req = 4'b1000; vblnk_in = 1'b1; vcount_in = 11'd600;
        tick();
        tick();
        n_vec++;
        if (gnt !== 4'b1000) begin
            n_err++; $display("FAIL fall_gnt3: got %b expected 1000", gnt);
        end
        tick(); tick();
        vblnk_in = 1'b0; vcount_in = 11'd0;
        tick();
        n_vec++;
        if ({gnt, window_open, busy, timeout_err} !== 7'h00) begin
            n_err++;
            $display("FAIL fall_revoke: got gnt=%b win=%b busy=%b err=%b expected all 0",
                     gnt, window_open, busy, timeout_err);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (gnt !== 4'b0000 || timeout_err !== 1'b0) begin
                n_err++;
                $display("FAIL fall_quiet c%0d: got gnt=%b err=%b expected gnt=0000 err=0",
                         c, gnt, timeout_err);
            end
        end
        req = '0;
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        n_vec++;
        if (frame_cnt !== 16'hFFFF) begin
            n_err++; $display("FAIL wrap_preload: got %h expected ffff", frame_cnt);
        end
        vblnk_in = 1'b1; vcount_in = 11'd600;
        tick();
        n_vec++;
        if (frame_cnt !== 16'd0 || frame_tick !== 1'b1) begin
            n_err++;
            $display("FAIL wrap: got cnt=%0d tick=%b expected cnt=0 tick=1", frame_cnt, frame_tick);
        end
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b1000;
        tick();
        n_vec++;
        if (gnt !== 4'b1000) begin
            n_err++; $display("FAIL rmg_gnt: got %b expected 1000", gnt);
        end
        tick();
        rst = 1'b1;
        tick();
        n_vec++;
        if ({gnt, frame_tick, window_open, timeout_err, busy} !== 8'h00 || frame_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL rmg_reset: got flags=%b cnt=%0d expected flags=00000000 cnt=0",
                     {gnt, frame_tick, window_open, timeout_err, busy}, frame_cnt);
        end
        rst = 1'b0; req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++;
            if ({gnt, frame_tick, window_open} !== 6'h00) begin
                n_err++;
                $display("FAIL rmg_no_tick c%0d: got gnt=%b tick=%b win=%b expected all 0",
                         c, gnt, frame_tick, window_open);
            end
        end
        vblnk_in = 1'b0; vcount_in = 11'd0;
        tick();
        vblnk_in = 1'b1; vcount_in = 11'd600;
        tick();
        n_vec++;
        if (frame_tick !== 1'b1 || frame_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL rmg_tick: got tick=%b cnt=%0d expected tick=1 cnt=1", frame_tick, frame_cnt);
        end
        tick();
        n_vec++;
        if (gnt !== 4'b0001) begin
            n_err++; $display("FAIL rmg_first: got %b expected 0001", gnt);
        end
        req = '0; done = 4'b0001;
        tick();
        done = '0;
    endtask

    initial begin
        test_reset();
        test_idle_frame();
        test_round_robin();
        test_timeout();
        test_guard();
        test_vblnk_fall();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
